// File: rtl/rvee_pcgen_pkg.sv
// Shared types and the redirect-target helper for the fetch PC generator.
package rvee_pcgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } pcgen_state_e;

  typedef logic epoch_t;

  // Computed at 64 bits; callers truncate to XLEN, which yields the mod-2^XLEN wrap.
  function automatic logic [63:0] pcgen_target(input logic [63:0] base, input logic [63:0] offset);
    logic [63:0] sum;
    sum    = base + offset;
    sum[0] = 1'b0;
    return sum;
  endfunction

endpackage

// File: rtl/rvee_pcgen_credit.sv
// Outstanding-fetch credit counter: issue increments, response decrements, full at MAX_OUTST.
module rvee_pcgen_credit
  import rvee_pcgen_pkg::*;
#(
  parameter int MAX_OUTST = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic       full,
  output logic [2:0] count
);

  logic [2:0] count_q, count_d;
  logic       inc_ok, dec_ok;

  always_comb begin
    full    = (count_q >= 3'(MAX_OUTST));
    inc_ok  = inc && !full;
    // A response with nothing outstanding is stray and must not underflow.
    dec_ok  = dec && (count_q != 3'd0);
    count_d = count_q;
    if (inc_ok && !dec_ok)
      count_d = count_q + 3'd1;
    else if (dec_ok && !inc_ok)
      count_d = count_q - 3'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count_q <= 3'd0;
    else
      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/rvee_pcgen_fw.sv
// Fetch PC generator with credit-limited issue, epoch-tagged redirects and late branch apply.
// Optional macro RVEE_PCGEN_MISALIGN_EN adds the misalign output and suppresses bit-1 targets.
//   state   | meaning
//   ST_IDLE | one cycle after reset, no fetch issued
//   ST_RUN  | issuing fetches, accepting redirects
//   ST_PEND | conditional-branch target latched, applied next edge
module rvee_pcgen_fw
  import rvee_pcgen_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              FETCH_BYTES = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              MAX_OUTST   = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            valid,
  input  logic            ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_ff,
  output logic            epoch,
  input  logic            rsp_valid,
  input  logic            jmp,
  input  logic            bcc,
  input  logic [XLEN-1:0] jmp_base,
  input  logic [XLEN-1:0] jmp_offset,
  output logic            jmp_ff,
  output logic            jmp_out,
  output logic            flush
`ifdef RVEE_PCGEN_MISALIGN_EN
  ,
  output logic            misalign
`endif
);

  localparam logic [XLEN-1:0] FB = XLEN'(FETCH_BYTES);

  pcgen_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_ff_q, pc_ff_d, tgt_q, tgt_d;
  epoch_t          epoch_q, epoch_d;
  logic            jmp_ff_q, jmp_out_q, jmp_out_d;
  logic [XLEN-1:0] target_w;
  logic            fire, credit_full;
  logic [2:0]      credit_cnt;
  logic            credit_unused;
`ifdef RVEE_PCGEN_MISALIGN_EN
  logic            mis_q, mis_d;
`endif

  assign target_w = XLEN'(pcgen_target(64'(jmp_base), 64'(jmp_offset)));
  // Registered state only, so a redirect never combinationally reaches the request.
  assign valid    = (state_q == ST_RUN) && !credit_full;
  assign fire     = valid && ready;

  rvee_pcgen_credit #(.MAX_OUTST(MAX_OUTST)) u_credit (
    .clk   (clk),
    .rst   (rst),
    .inc   (fire),
    .dec   (rsp_valid),
    .full  (credit_full),
    .count (credit_cnt)
  );

  assign credit_unused = ^credit_cnt;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_ff_d   = pc_ff_q;
    tgt_d     = tgt_q;
    epoch_d   = epoch_q;
    jmp_out_d = 1'b0;
`ifdef RVEE_PCGEN_MISALIGN_EN
    mis_d     = 1'b0;
`endif
    if (fire) begin
      pc_ff_d = pc_q;
      pc_d    = (pc_q & ~(FB - 1'b1)) + FB;
    end
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN: begin
        if (jmp) begin
`ifdef RVEE_PCGEN_MISALIGN_EN
          if (target_w[1])
            mis_d = 1'b1;
          else
`endif
          if (bcc) begin
            tgt_d   = target_w;
            state_d = ST_PEND;
          end else begin
            pc_d      = target_w;
            epoch_d   = ~epoch_q;
            jmp_out_d = 1'b1;
          end
        end
      end
      ST_PEND: begin
        pc_d      = tgt_q;
        epoch_d   = ~epoch_q;
        jmp_out_d = 1'b1;
        state_d   = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      pc_ff_q   <= RESET_PC;
      tgt_q     <= '0;
      epoch_q   <= 1'b0;
      jmp_ff_q  <= 1'b0;
      jmp_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_ff_q   <= pc_ff_d;
      tgt_q     <= tgt_d;
      epoch_q   <= epoch_d;
      jmp_ff_q  <= jmp;
      jmp_out_q <= jmp_out_d;
    end
  end

`ifdef RVEE_PCGEN_MISALIGN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      mis_q <= 1'b0;
    else
      mis_q <= mis_d;
  end

  assign misalign = mis_q;
`endif

  assign pc      = pc_q;
  assign pc_ff   = pc_ff_q;
  assign epoch   = epoch_q;
  assign jmp_ff  = jmp_ff_q;
  assign jmp_out = jmp_out_q;
  assign flush   = jmp_out_q;

endmodule
